// File: rtl/checkout_pkg.sv
// Shared types and defaults for the checkout transaction controller.
// Imported by the controller top and the item-code decoder.
package checkout_pkg;

    localparam int DEF_MAX_ITEMS = 15;
    localparam int DEF_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ALARM = 2'd2,
        TOTAL = 2'd3
    } chk_state_t;

    // Per-item classification produced by the decoder.
    typedef struct packed {
        logic disc;
        logic stolen;
    } upc_flags_t;

endpackage

// File: rtl/upc_status.sv
// Combinational item classifier: {upc, mark} -> discounted / stolen flags.
// Any code not listed below is an ordinary item.
module upc_status
    import checkout_pkg::*;
(
    input  logic [2:0] upc,
    input  logic       mark,
    output upc_flags_t flags
);

    always_comb begin
        flags = '{disc: 1'b0, stolen: 1'b0};
        case ({upc, mark})
            4'b0000: flags = '{disc: 1'b0, stolen: 1'b1};
            4'b0110: flags = '{disc: 1'b1, stolen: 1'b0};
            4'b1000: flags = '{disc: 1'b0, stolen: 1'b1};
            4'b1010: flags = '{disc: 1'b1, stolen: 1'b1};
            4'b1011: flags = '{disc: 1'b1, stolen: 1'b0};
            4'b1100: flags = '{disc: 1'b1, stolen: 1'b0};
            default: flags = '{disc: 1'b0, stolen: 1'b0};
        endcase
    end

endmodule

// File: rtl/checkout_ctrl.sv
// Checkout transaction sequencer: accepts scanned items, tallies counts,
// halts on a stolen item until the clerk acknowledges the alarm.
//
// state | meaning
// IDLE  | no transaction since reset
// SCAN  | accepting items
// ALARM | stolen item seen, scanning halted until alarm_ack
// TOTAL | transaction finished, counts final
module checkout_ctrl
    import checkout_pkg::*;
#(
    parameter int MAX_ITEMS = DEF_MAX_ITEMS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             scan_valid,
    input  logic [2:0]       scan_upc,
    input  logic             scan_mark,
    output logic             scan_ready,
    input  logic             finish,
    input  logic             alarm_ack,
    output logic             alarm,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] disc_count,
    output logic [CNT_W-1:0] stolen_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITEMS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chk_state_t       state, state_next;
    logic [CNT_W-1:0] item_q, disc_q, stolen_q;
    logic [CNT_W-1:0] item_d, disc_d, stolen_d;
    logic [CNT_W-1:0] item_inc;
    logic             pend_q, pend_d;
    logic             accept;
    upc_flags_t       flags;

    upc_status u_upc_status (
        .upc   (scan_upc),
        .mark  (scan_mark),
        .flags (flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            item_q   <= '0;
            disc_q   <= '0;
            stolen_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state    <= state_next;
            item_q   <= item_d;
            disc_q   <= disc_d;
            stolen_q <= stolen_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_next = state;
        item_d     = item_q;
        disc_d     = disc_q;
        stolen_d   = stolen_q;
        pend_d     = pend_q;
        item_inc   = item_q + CNT_ONE;
        accept     = scan_valid && (state == SCAN);

        scan_ready = (state == SCAN);
        alarm      = (state == ALARM);
        busy       = (state == SCAN) || (state == ALARM);
        done       = (state == TOTAL);

        case (state)
            IDLE, TOTAL: begin
                if (start) begin
                    state_next = SCAN;
                    item_d     = '0;
                    disc_d     = '0;
                    stolen_d   = '0;
                    pend_d     = 1'b0;
                end
            end
            SCAN: begin
                if (accept) begin
                    item_d   = item_inc;
                    disc_d   = disc_q + CNT_W'(flags.disc);
                    stolen_d = stolen_q + CNT_W'(flags.stolen);
                    // A stolen item wins over the cap and over finish; finish is remembered.
                    if (flags.stolen) begin
                        state_next = ALARM;
                        pend_d     = finish;
                    end else if (item_inc == CNT_MAX || finish) begin
                        state_next = TOTAL;
                    end
                end else if (finish) begin
                    state_next = TOTAL;
                end
            end
            ALARM: begin
                if (alarm_ack) begin
                    state_next = (pend_q || finish || item_q == CNT_MAX) ? TOTAL : SCAN;
                    pend_d     = 1'b0;
                end else if (finish) begin
                    pend_d = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign item_count   = item_q;
    assign disc_count   = disc_q;
    assign stolen_count = stolen_q;

endmodule
